// File: rtl/imm_decode_pipe_pkg.sv
// Shared types and constants for the immediate-decode pipeline.
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5
   } imm_fmt_e;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   function automatic bit xlen_legal(int x);
      return (x == 32) || (x == 64);
   endfunction

endpackage

// File: rtl/imm_decode_pipe_if.sv
// Upstream/downstream handshake bundle for imm_decode_pipe; out_illegal
// exists only when IMM_DECODE_ILLEGAL_CHK_EN is defined.
interface imm_decode_pipe_if
   import imm_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int INSTRUCTION = 32
);
   logic                   flush;
   logic                   in_valid;
   logic                   in_ready;
   logic [INSTRUCTION-1:0] in_instr;
   logic [XLEN-1:0]        in_pc;
   logic                   out_valid;
   logic                   out_ready;
   logic [INSTRUCTION-1:0] out_instr;
   logic [XLEN-1:0]        out_pc;
   imm_fmt_e               out_fmt;
   logic [XLEN-1:0]        out_imm;
   logic [XLEN-1:0]        out_target;
`ifdef IMM_DECODE_ILLEGAL_CHK_EN
   logic                   out_illegal;
`endif

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_fmt, out_imm, out_target
`ifdef IMM_DECODE_ILLEGAL_CHK_EN
      , input out_illegal
`endif
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_fmt, out_imm, out_target
`ifdef IMM_DECODE_ILLEGAL_CHK_EN
      , output out_illegal
`endif
   );
endinterface

// File: rtl/imm_decode_pipe_extract.sv
// Combinational RV32I immediate extraction, sign-extended from bit 31 to XLEN.
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   output imm_fmt_e        fmt_o,
`ifdef IMM_DECODE_ILLEGAL_CHK_EN
   output logic            illegal_o,
`endif
   output logic [XLEN-1:0] imm_o
);
   logic signed [31:0] imm32;

   always_comb begin
      fmt_o = FMT_NONE;
      imm32 = '0;
      unique case (instr_i[6:0])
         OP_IMM, OP_LOAD, OP_JALR: begin
            fmt_o = FMT_I;
            imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
         end
         OP_STORE: begin
            fmt_o = FMT_S;
            imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         end
         OP_BRANCH: begin
            fmt_o = FMT_B;
            imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            fmt_o = FMT_U;
            imm32 = {instr_i[31:12], 12'b0};
         end
         OP_JAL: begin
            fmt_o = FMT_J;
            imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
         end
         default: ;
      endcase
   end

   // signed size cast replicates bit 31 into the upper half when XLEN is 64
   assign imm_o = XLEN'(imm32);

`ifdef IMM_DECODE_ILLEGAL_CHK_EN
   assign illegal_o = (fmt_o == FMT_NONE) || (instr_i[1:0] != 2'b11);
`endif
endmodule

// File: rtl/imm_decode_pipe.sv
// 1-cycle immediate decode stage behind a 2-entry skid buffer; in_ready is a register.
// Optional out_illegal flag is built when IMM_DECODE_ILLEGAL_CHK_EN is defined.
module imm_decode_pipe
   import imm_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int INSTRUCTION = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   imm_decode_pipe_if.slave bus
);
   if (!xlen_legal(XLEN) || INSTRUCTION != 32) begin : g_bad_param
      $error("imm_decode_pipe: XLEN must be 32 or 64 and INSTRUCTION must be 32");
   end

   typedef struct packed {
      logic [INSTRUCTION-1:0] instr;
      logic [XLEN-1:0]        pc;
      imm_fmt_e               fmt;
      logic [XLEN-1:0]        imm;
      logic [XLEN-1:0]        tgt;
`ifdef IMM_DECODE_ILLEGAL_CHK_EN
      logic                   ill;
`endif
   } word_t;

   word_t    main_q, main_d, skid_q, skid_d, in_word;
   logic     main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q;
   logic     in_hs, out_hs;
   imm_fmt_e ext_fmt;
   logic [XLEN-1:0] ext_imm;
`ifdef IMM_DECODE_ILLEGAL_CHK_EN
   logic     ext_ill;
`endif

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr_i   (bus.in_instr),
      .fmt_o     (ext_fmt),
`ifdef IMM_DECODE_ILLEGAL_CHK_EN
      .illegal_o (ext_ill),
`endif
      .imm_o     (ext_imm)
   );

   always_comb begin
      in_word       = '0;
      in_word.instr = bus.in_instr;
      in_word.pc    = bus.in_pc;
      in_word.fmt   = ext_fmt;
      in_word.imm   = ext_imm;
      in_word.tgt   = bus.in_pc + ext_imm;
`ifdef IMM_DECODE_ILLEGAL_CHK_EN
      in_word.ill   = ext_ill;
`endif
   end

   assign in_hs  = bus.in_valid && rdy_q;
   assign out_hs = main_vld_q && bus.out_ready;

   // in_hs cannot coincide with a full skid because rdy_q mirrors !skid_vld_q
   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (bus.flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (skid_vld_q) begin
         if (out_hs) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
         end
      end else if (main_vld_q && !out_hs) begin
         if (in_hs) begin
            skid_d     = in_word;
            skid_vld_d = 1'b1;
         end
      end else begin
         main_vld_d = in_hs;
         if (in_hs) main_d = in_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         rdy_q      <= !skid_vld_d;
      end
   end

   assign bus.in_ready   = rdy_q;
   assign bus.out_valid  = main_vld_q;
   assign bus.out_instr  = main_q.instr;
   assign bus.out_pc     = main_q.pc;
   assign bus.out_fmt    = main_q.fmt;
   assign bus.out_imm    = main_q.imm;
   assign bus.out_target = main_q.tgt;
`ifdef IMM_DECODE_ILLEGAL_CHK_EN
   assign bus.out_illegal = main_q.ill;
`endif
endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed bench for imm_decode_pipe: XLEN=32 main instance plus an XLEN=64 instance.
module tb_imm_decode_pipe;
   import imm_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   imm_decode_pipe_if #(.XLEN(32)) bus ();
   imm_decode_pipe_if #(.XLEN(64)) bus64 ();

   imm_decode_pipe #(.XLEN(32), .INSTRUCTION(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   imm_decode_pipe #(.XLEN(64), .INSTRUCTION(32)) dut64 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus64)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] pc);
      bus.in_valid = vld;
      bus.in_instr = instr;
      bus.in_pc    = pc;
   endtask

   // instr, pc, fmt, imm, target
   logic [31:0] v_instr [7] = '{32'hFFF00093, 32'hFE000EE3, 32'hFE112E23, 32'h12345037,
                                32'h0080006F, 32'h00000033, 32'h00A00067};
   logic [31:0] v_pc    [7] = '{32'h100, 32'h200, 32'h300, 32'h10, 32'h400, 32'h500, 32'h40};
   logic [2:0]  v_fmt   [7] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1};
   logic [31:0] v_imm   [7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000,
                                32'h8, 32'h0, 32'hA};
   logic [31:0] v_tgt   [7] = '{32'hFF, 32'h1FC, 32'h2FC, 32'h12345010, 32'h408, 32'h500, 32'h4A};

   initial begin
      rst_n = 1'b0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      bus64.flush = 1'b0;
      bus64.in_valid = 1'b0;
      bus64.in_instr = '0;
      bus64.in_pc = '0;
      bus64.out_ready = 1'b0;
      tick();
      tick();

      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_fmt", bus.out_fmt, 0);
      check("rst_out_imm", bus.out_imm, 0);
      check("rst_out_target", bus.out_target, 0);
      check("rst_out_pc", bus.out_pc, 0);
      check("rst_out_instr", bus.out_instr, 0);
      check("rst_skid_valid", dut.skid_vld_q, 0);
      check("rst64_out_valid", bus64.out_valid, 0);
`ifdef IMM_DECODE_ILLEGAL_CHK_EN
      check("rst_out_illegal", bus.out_illegal, 0);
`endif

      rst_n = 1'b1;
      check("rel_in_ready_low", bus.in_ready, 0);
      tick();
      check("rel_in_ready_high", bus.in_ready, 1);

      // back-to-back stream, one word per cycle
      bus.out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, v_instr[i], v_pc[i]);
         tick();
         check($sformatf("vec%0d_valid", i), bus.out_valid, 1);
         check($sformatf("vec%0d_instr", i), bus.out_instr, v_instr[i]);
         check($sformatf("vec%0d_fmt", i), bus.out_fmt, v_fmt[i]);
         check($sformatf("vec%0d_imm", i), bus.out_imm, v_imm[i]);
         check($sformatf("vec%0d_tgt", i), bus.out_target, v_tgt[i]);
         check($sformatf("vec%0d_in_ready", i), bus.in_ready, 1);
`ifdef IMM_DECODE_ILLEGAL_CHK_EN
         check($sformatf("vec%0d_illegal", i), bus.out_illegal, (v_fmt[i] == 3'd0));
`endif
      end
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("drain_out_valid", bus.out_valid, 0);

      // back-pressure: A, B, C with out_ready low
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h00100093, 32'h0);
      tick();
      check("bp_a_out", bus.out_instr, 32'h00100093);
      check("bp_a_in_ready", bus.in_ready, 1);
      drive(1'b1, 32'h00200093, 32'h0);
      tick();
      check("bp_b_in_ready", bus.in_ready, 0);
      check("bp_b_hold", bus.out_instr, 32'h00100093);
      drive(1'b1, 32'h00300093, 32'h0);
      tick();
      check("bp_c_in_ready", bus.in_ready, 0);
      check("bp_c_hold", bus.out_instr, 32'h00100093);
      check("bp_c_hold_imm", bus.out_imm, 32'h1);
      bus.out_ready = 1'b1;
      tick();
      check("bp_emit_b", bus.out_instr, 32'h00200093);
      check("bp_emit_b_valid", bus.out_valid, 1);
      check("bp_ready_back", bus.in_ready, 1);
      tick();
      check("bp_emit_c", bus.out_instr, 32'h00300093);
      check("bp_emit_c_imm", bus.out_imm, 32'h3);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("bp_drained", bus.out_valid, 0);

      // flush with both entries full and a word offered
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h0D000093, 32'h0);
      tick();
      drive(1'b1, 32'h0E000093, 32'h0);
      tick();
      check("fl_full_in_ready", bus.in_ready, 0);
      drive(1'b1, 32'h0F000093, 32'h0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("fl_out_valid", bus.out_valid, 0);
      check("fl_in_ready", bus.in_ready, 1);
      // flush with only main held and an accepted word in the same cycle
      drive(1'b1, 32'h0D100093, 32'h0);
      tick();
      drive(1'b1, 32'h0F100093, 32'h0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("fl2_out_valid", bus.out_valid, 0);
      drive(1'b0, 32'h0, 32'h0);
      bus.out_ready = 1'b1;
      tick();
      check("fl_no_ghost", bus.out_valid, 0);
      drive(1'b1, 32'h07700093, 32'h0);
      tick();
      check("fl_next_word", bus.out_instr, 32'h07700093);
      check("fl_next_valid", bus.out_valid, 1);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("fl_after_empty", bus.out_valid, 0);

      // asynchronous reset mid-stream
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h01100093, 32'h0);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_out_valid", bus.out_valid, 0);
      check("mrst_in_ready", bus.in_ready, 0);
      check("mrst_out_instr", bus.out_instr, 0);
      tick();
      check("mrst_in_ready_held", bus.in_ready, 0);
      rst_n = 1'b1;
      tick();
      check("mrst_in_ready_rel", bus.in_ready, 1);
      check("mrst_out_valid_rel", bus.out_valid, 0);

      // 64-bit datapath sign extension
      bus64.out_ready = 1'b1;
      bus64.in_valid = 1'b1;
      bus64.in_instr = 32'h12345037;
      tick();
      check("x64_lui_pos", bus64.out_imm, 64'h0000000012345000);
      check("x64_lui_fmt", bus64.out_fmt, 4);
      bus64.in_instr = 32'h80000037;
      tick();
      check("x64_lui_neg", bus64.out_imm, 64'hFFFFFFFF80000000);
      bus64.in_instr = 32'hFE000EE3;
      bus64.in_pc = 64'h200;
      tick();
      check("x64_beq_tgt", bus64.out_target, 64'h1FC);
      bus64.in_valid = 1'b0;

`ifdef IMM_DECODE_ILLEGAL_CHK_EN
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h0000007F, 32'h0);
      tick();
      check("ill_flag", bus.out_illegal, 1);
      check("ill_fmt", bus.out_fmt, 0);
      check("ill_imm", bus.out_imm, 0);
      check("ill_valid", bus.out_valid, 1);
      drive(1'b1, 32'h00100090, 32'h0);
      tick();
      check("ill_low_bits", bus.out_illegal, 1);
      drive(1'b1, 32'h00100093, 32'h0);
      tick();
      check("ill_clear", bus.out_illegal, 0);
      drive(1'b0, 32'h0, 32'h0);
`endif

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
